// File: rtl/fft_bf_pkg.sv
// fft_bf_pkg -- shared constants and types for the butterfly pipeline.
//
// Number formats (unsigned fixed point, modular arithmetic):
//   FP4 : 8-bit  value, 4 fractional bits (Q4.4), stored in mem[7:0]
//   FP8 : 16-bit value, 8 fractional bits (Q8.8), stored in mem[23:8]
// The twiddle is always supplied as Q8.8; an FP4 multiply uses its
// Q4.4 view (w[11:4]).
package fft_bf_pkg;

    localparam int MEM_W    = 24;
    localparam int IO_W     = 16;
    localparam int FP4_W    = 8;
    localparam int FP8_W    = MEM_W - FP4_W;
    localparam int FP8_FRAC = FP8_W / 2;
    localparam int FP4_FRAC = FP4_W / 2;

    // Bit positions inside the 2-bit mode field.
    localparam int MODE_MUL_BIT = 1;
    localparam int MODE_ADD_BIT = 0;

    typedef enum logic [1:0] {
        MODE_FP4_FP4   = 2'b00,
        MODE_FP4M_FP8A = 2'b01,
        MODE_FP8M_FP4A = 2'b10,
        MODE_FP8_FP8   = 2'b11
    } bf_mode_e;

    typedef struct packed {
        logic [IO_W-1:0] x;
        logic [IO_W-1:0] y;
        logic            is_fp8;
    } bf_result_t;

endpackage

// File: rtl/bf_butterfly.sv
// bf_butterfly -- combinational butterfly X = A + B*W, Y = A - B*W.
//   MUL_W : width of the multiply format (FP4_W or FP8_W)
//   ADD_W : width of the add format      (FP4_W or FP8_W)
// Ports: a (ADD_W) add operand, b/w (MUL_W) multiply operands,
//        x/y (ADD_W) results. The product is realigned from the multiply
//        format's binary point to the add format's before the add.
module bf_butterfly
    import fft_bf_pkg::*;
#(
    parameter int MUL_W = FP8_W,
    parameter int ADD_W = FP8_W
) (
    input  logic [ADD_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    input  logic [MUL_W-1:0] w,
    output logic [ADD_W-1:0] x,
    output logic [ADD_W-1:0] y
);

    logic [2*MUL_W-1:0] prod;
    logic [MUL_W-1:0]   t_mul;
    logic [ADD_W-1:0]   t_add;

    // Fixed-point multiply: drop the extra fractional bits, keep the low word.
    assign prod  = (2*MUL_W)'(b) * (2*MUL_W)'(w);
    assign t_mul = MUL_W'(prod >> (MUL_W / 2));

    generate
        if (ADD_W > MUL_W) begin : g_widen
            assign t_add = ADD_W'(t_mul) << ((ADD_W - MUL_W) / 2);
        end else if (ADD_W < MUL_W) begin : g_narrow
            assign t_add = ADD_W'(t_mul >> ((MUL_W - ADD_W) / 2));
        end else begin : g_same
            assign t_add = t_mul;
        end
    endgenerate

    assign x = a + t_add;
    assign y = a - t_add;

endmodule

// File: rtl/bf_pipe_stage.sv
// bf_pipe_stage -- one valid/ready register slice.
// Ports: clk, rst_n (async, active-low), in_valid/in_ready/in_data from the
//        previous slice, out_valid/out_ready/out_data toward the next one.
// The slice loads whenever it is empty or its content leaves this cycle,
// so a full pipeline still moves one item per cycle.
module bf_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    assign in_ready  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_ready) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                data_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/butterfly_pipe_wrapper.sv
// butterfly_pipe_wrapper -- mixed-precision butterfly with an elastic
// output pipeline.
// Parameters: PIPE_STAGES (1..4) register slices, TAG_W sideband width.
// Ports: clk, rst_n (async active-low); in_valid/in_ready handshake with
//        in_mode, in_a, in_b, in_w, in_tag; out_valid/out_ready handshake
//        with out_x, out_y, out_is_fp8, out_tag; busy = any slice occupied.
// Build option: define BF_PERF_CNT_EN to add output stall_cnt, a saturating
//        count of cycles where out_valid is high and out_ready low.
module butterfly_pipe_wrapper
    import fft_bf_pkg::*;
#(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [MEM_W-1:0] in_a,
    input  logic [MEM_W-1:0] in_b,
    input  logic [IO_W-1:0]  in_w,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IO_W-1:0]  out_x,
    output logic [IO_W-1:0]  out_y,
    output logic             out_is_fp8,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
`ifdef BF_PERF_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int PAY_W = $bits(bf_result_t) + TAG_W;

    logic [3:0][IO_W-1:0]              var_x;
    logic [3:0][IO_W-1:0]              var_y;
    bf_result_t                        sel_res;
    bf_result_t                        out_res;
    logic [PIPE_STAGES:0]              stage_valid;
    logic [PIPE_STAGES:0]              stage_ready;
    logic [PIPE_STAGES:0][PAY_W-1:0]   stage_data;

    // All four precision variants run in parallel; variant index == mode.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_var
            localparam logic [1:0] VMODE = 2'(gi);
            localparam bit MUL8 = VMODE[MODE_MUL_BIT];
            localparam bit ADD8 = VMODE[MODE_ADD_BIT];
            localparam int MW   = MUL8 ? FP8_W : FP4_W;
            localparam int AW   = ADD8 ? FP8_W : FP4_W;

            logic [MW-1:0] b_op;
            logic [MW-1:0] w_op;
            logic [AW-1:0] a_op;
            logic [AW-1:0] x_r;
            logic [AW-1:0] y_r;

            if (MUL8) begin : g_m8
                assign b_op = in_b[MEM_W-1:FP4_W];
                assign w_op = in_w;
            end else begin : g_m4
                assign b_op = in_b[FP4_W-1:0];
                assign w_op = in_w[FP8_FRAC-FP4_FRAC +: FP4_W];
            end

            if (ADD8) begin : g_a8
                assign a_op = in_a[MEM_W-1:FP4_W];
            end else begin : g_a4
                assign a_op = in_a[FP4_W-1:0];
            end

            bf_butterfly #(
                .MUL_W (MW),
                .ADD_W (AW)
            ) u_bf (
                .a (a_op),
                .b (b_op),
                .w (w_op),
                .x (x_r),
                .y (y_r)
            );

            // FP4 add results are zero-extended into the 16-bit output.
            assign var_x[gi] = IO_W'(x_r);
            assign var_y[gi] = IO_W'(y_r);
        end
    endgenerate

    always_comb begin
        sel_res        = '0;
        sel_res.x      = var_x[in_mode];
        sel_res.y      = var_y[in_mode];
        sel_res.is_fp8 = in_mode[MODE_ADD_BIT];
    end

    // Slice chain: index 0 is the wrapper input, index PIPE_STAGES the output.
    assign stage_valid[0]           = in_valid;
    assign stage_data[0]            = {sel_res, in_tag};
    assign in_ready                 = stage_ready[0];
    assign stage_ready[PIPE_STAGES] = out_ready;

    generate
        for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            bf_pipe_stage #(
                .W (PAY_W)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (stage_valid[gi]),
                .in_ready  (stage_ready[gi]),
                .in_data   (stage_data[gi]),
                .out_valid (stage_valid[gi+1]),
                .out_ready (stage_ready[gi+1]),
                .out_data  (stage_data[gi+1])
            );
        end
    endgenerate

    assign {out_res, out_tag} = stage_data[PIPE_STAGES];
    assign out_x      = out_res.x;
    assign out_y      = out_res.y;
    assign out_is_fp8 = out_res.is_fp8;
    assign out_valid  = stage_valid[PIPE_STAGES];
    assign busy       = |stage_valid[PIPE_STAGES:1];

`ifdef BF_PERF_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_butterfly_pipe_wrapper.sv
// tb_butterfly_pipe_wrapper -- directed + random bench for the butterfly
// pipeline. Expected results come from an arithmetic reference model and
// a FIFO scoreboard; inputs change 1 time unit after the rising edge and
// DUT outputs are sampled on the falling edge.
module tb_butterfly_pipe_wrapper;

    localparam int TAG_W = 4;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        fp8;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [23:0] in_a;
    logic [23:0] in_b;
    logic [15:0] in_w;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic        out_is_fp8;
    logic [3:0]  out_tag;
    logic        busy;
`ifdef BF_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    butterfly_pipe_wrapper #(
        .PIPE_STAGES (2),
        .TAG_W       (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_w       (in_w),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_is_fp8 (out_is_fp8),
        .out_tag    (out_tag),
        .busy       (busy)
`ifdef BF_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    int   tag_log[$];
    int   fp8_log[$];
    int   acc_log[$];
    bit   hold_chk = 1'b0;
    logic [15:0] hold_x, hold_y;
    logic        hold_fp8;
    logic [3:0]  hold_tag;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Reference butterfly computed from the number formats directly:
    // FP8 = Q8.8 in 16 bits, FP4 = Q4.4 in 8 bits, all modular.
    function automatic exp_t model(input logic [1:0] mode, input logic [23:0] a,
                                   input logic [23:0] b, input logic [15:0] w,
                                   input logic [3:0] tag);
        longint unsigned p, t, ta, av, w4, m;
        exp_t e;
        if (mode[1]) begin
            p = longint'(b[23:8]) * longint'(w);
            t = (p / 256) % 65536;
        end else begin
            w4 = (longint'(w) / 16) % 256;
            p  = longint'(b[7:0]) * w4;
            t  = (p / 16) % 256;
        end
        if (mode[0]) begin
            m  = 65536;
            ta = mode[1] ? t : (t * 16) % m;
            av = longint'(a[23:8]);
        end else begin
            m  = 256;
            ta = mode[1] ? (t / 16) % m : t;
            av = longint'(a[7:0]);
        end
        e.x   = 16'((av + ta) % m);
        e.y   = 16'((av + m - ta) % m);
        e.fp8 = mode[0];
        e.tag = tag;
        return e;
    endfunction

    task automatic randomize_fields();
        in_mode = 2'($urandom_range(0, 3));
        in_a    = 24'($urandom);
        in_b    = 24'($urandom);
        in_w    = 16'($urandom);
        in_tag  = 4'($urandom);
    endtask

    // One clock: sample handshakes on the falling edge, score outputs,
    // then advance past the rising edge.
    task automatic tick();
        bit   acc, take;
        exp_t e;
        @(negedge clk);
        if (hold_chk) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_x", out_x, hold_x);
            chk("hold_y", out_y, hold_y);
            chk("hold_fp8", out_is_fp8, hold_fp8);
            chk("hold_tag", out_tag, hold_tag);
        end
        hold_chk = out_valid && !out_ready;
        hold_x = out_x; hold_y = out_y; hold_fp8 = out_is_fp8; hold_tag = out_tag;
        acc  = in_valid && in_ready;
        take = out_valid && out_ready;
        if (take) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_x", out_x, e.x);
                chk("out_y", out_y, e.y);
                chk("out_is_fp8", out_is_fp8, e.fp8);
                chk("out_tag", out_tag, e.tag);
                tag_log.push_back(int'(out_tag));
                fp8_log.push_back(int'(out_is_fp8));
            end
        end
        if (acc) begin
            exp_q.push_back(model(in_mode, in_a, in_b, in_w, in_tag));
            acc_log.push_back(int'(in_tag));
        end
        @(posedge clk);
        #1;
        chk("busy", busy, exp_q.size() != 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tag_log.delete();
        fp8_log.delete();
        acc_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_mode = 2'b00; in_a = '0; in_b = '0; in_w = '0; in_tag = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_is_fp8", out_is_fp8, 0);
        chk("rst_out_tag", out_tag, 0);
        release_reset();
        chk("rst_in_ready", in_ready, 1);

        // FP8/FP8 all-zero operands: latency of two cycles
        in_valid = 1'b1; in_mode = 2'b11; in_a = '0; in_b = '0; in_w = '0; in_tag = 4'd5;
        tick();
        in_valid = 1'b0;
        chk("lat_cycle1_valid", out_valid, 0);
        tick();
        chk("lat_cycle2_valid", out_valid, 1);
        chk("zero_x", out_x, 16'h0000);
        chk("zero_y", out_y, 16'h0000);
        chk("zero_fp8", out_is_fp8, 1);
        tick();

        // FP4/FP4 ignores upper operand bytes
        in_valid = 1'b1; in_mode = 2'b00; in_a = 24'hABCD00; in_b = 24'h123400; in_w = '0; in_tag = 4'd6;
        tick();
        in_valid = 1'b0;
        tick();
        chk("fp4_x", out_x, 16'h0000);
        chk("fp4_y", out_y, 16'h0000);
        chk("fp4_fp8", out_is_fp8, 0);
        tick();

        // Interleaved modes back to back
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            randomize_fields();
            in_valid = 1'b1; in_mode = 2'(i); in_tag = 4'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        chk("mix_count", tag_log.size(), 4);
        for (int i = 0; i < tag_log.size(); i++) begin
            chk("mix_tag", tag_log[i], i + 1);
            chk("mix_fp8", fp8_log[i], i % 2);
        end

        // Back-pressure: only two fit, output held, order kept on release
        clear_logs();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            randomize_fields();
            in_valid = 1'b1;
            in_tag = 4'(acc_log.size());
            tick();
        end
        chk("bp_accepted", acc_log.size(), 2);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && acc_log.size() < 4; i++) begin
            randomize_fields();
            in_valid = 1'b1;
            in_tag = 4'(acc_log.size());
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accept_all", acc_log.size(), 4);
        repeat (4) tick();
        chk("bp_out_count", tag_log.size(), 4);
        for (int i = 0; i < tag_log.size(); i++) begin
            chk("bp_order", tag_log[i], i);
        end

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            randomize_fields();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
        chk("rand_drained", exp_q.size(), 0);

        // Reset with two transactions in flight
        for (int i = 0; i < 2; i++) begin
            randomize_fields();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_x", out_x, 0);
        exp_q.delete();
        hold_chk = 1'b0;
        repeat (2) tick();
        release_reset();
        chk("post_rst_in_ready", in_ready, 1);
        repeat (5) tick();

`ifdef BF_PERF_CNT_EN
        chk("stall_cnt_reset", stall_cnt, 0);
        out_ready = 1'b0;
        randomize_fields();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        repeat (10) tick();
        chk("stall_cnt_10", stall_cnt, 10);
        force dut.stall_cnt_reg = 16'hFFFF;
        tick();
        release dut.stall_cnt_reg;
        repeat (2) tick();
        chk("stall_cnt_sat", stall_cnt, 16'hFFFF);
        out_ready = 1'b1;
        repeat (3) tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
